serial_adder_n: RTL

SERIAL_ADDER_N -- requirements
Module: serial_adder_n

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_n_fa_cell.sv | 17 +
 rtl/serial_adder_n.sv | 124 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants for the bit-serial adder/subtractor.
//   state_e  : controller states (IDLE, RUN, DONE)
//   MODE_ADD : sub input value selecting a + b + ci
//   MODE_SUB : sub input value selecting a - b - ci
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_n_fa_cell.sv
// fa_cell: single-bit combinational full adder.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: bit-serial adder/subtractor that handles one bit per clock, LSB first.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   start  : request; operands are captured when it is accepted (IDLE or DONE)
//   sub    : 0 = a + b + ci, 1 = a - b - ci (ci acts as borrow-in)
//   ci     : carry-in / borrow-in
//   a, b   : operands, WIDTH bits
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, result valid
//   s      : sum/difference, held until the next result
//   co     : final carry (subtract: 1 = no borrow)
//   ovf    : signed overflow
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             ci,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is a + ~b + 1; a borrow-in removes the +1.
          a_d     = a;
          b_d     = (sub == MODE_SUB) ? ~b : b;
          carry_d = ci ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q is the carry into the MSB on this final step.
          state_d = DONE;
          s_d     = sum_d;
          co_d    = fa_co;
          ovf_d   = carry_q ^ fa_co;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule
